// File: rtl/mod_updown_counter.sv
// Synchronous up/down modulo counter with load, clear, enable prescaler, tc pulse and sticky ovf.
// Define COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module mod_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o
);

  localparam int unsigned      PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MaxCnt  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   ModExt  = (WIDTH + 1)'(MODULO);
  localparam logic [PreW-1:0]  PreLast = PreW'(PRESCALE - 1);

  if (WIDTH < 1) begin : gen_bad_width
    $error("mod_updown_counter: WIDTH must be >= 1");
  end
  if (MODULO < 2 || 64'(MODULO) > (64'd1 << WIDTH)) begin : gen_bad_modulo
    $error("mod_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end
  if (PRESCALE < 1) begin : gen_bad_prescale
    $error("mod_updown_counter: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_bound;

  always_comb begin
    count_d  = count_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    at_bound = up_i ? (count_q == MaxCnt) : (count_q == '0);
    if (clr_i) begin
      count_d = '0;
      pre_d   = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      count_d = ({1'b0, load_val_i} >= ModExt) ? MaxCnt : load_val_i;
      pre_d   = '0;
    end else if (en_i) begin
      if (pre_q == PreLast) begin
        pre_d = '0;
        if (at_bound) begin
          // Step attempted at a bound: wrap (or hold when saturating), flag it either way.
          tc_d  = 1'b1;
          ovf_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = up_i ? '0 : MaxCnt;
`endif
        end else begin
          count_d = up_i ? count_q + 1'b1 : count_q - 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: default build and WIDTH=4/MODULO=10/PRESCALE=3 side by side,
// both compared every cycle against an arithmetic reference model.
module tb_mod_updown_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni, clr_i, load_i, en_i, up_i;
  logic [3:0] load_val_i;
  logic [3:0] cnt0, cnt1;
  logic       tc0, tc1, ovf0, ovf1;

  int m_cnt [2];
  int m_pre [2];
  bit m_tc  [2];
  bit m_ovf [2];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mod_updown_counter u_dut_def (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .en_i       (en_i),
    .up_i       (up_i),
    .count_o    (cnt0),
    .tc_o       (tc0),
    .ovf_o      (ovf0)
  );

  mod_updown_counter #(
    .WIDTH    (4),
    .MODULO   (10),
    .PRESCALE (3)
  ) u_dut_m10 (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .en_i       (en_i),
    .up_i       (up_i),
    .count_o    (cnt1),
    .tc_o       (tc1),
    .ovf_o      (ovf1)
  );

  function automatic int mod_of(input int d);
    return (d == 0) ? 16 : 10;
  endfunction

  function automatic int pre_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      m_pre[d] = 0;
      m_tc[d]  = 1'b0;
      m_ovf[d] = 1'b0;
    end
  endtask

  // One rising edge of the reference: clr beats load beats step; a step every PRESCALE enables.
  task automatic model_edge(input int d);
    int m;
    int nxt;
    m = mod_of(d);
    m_tc[d] = 1'b0;
    if (clr_i) begin
      m_cnt[d] = 0;
      m_pre[d] = 0;
      m_ovf[d] = 1'b0;
    end else if (load_i) begin
      m_cnt[d] = (int'(load_val_i) >= m) ? m - 1 : int'(load_val_i);
      m_pre[d] = 0;
    end else if (en_i) begin
      m_pre[d] = m_pre[d] + 1;
      if (m_pre[d] == pre_of(d)) begin
        m_pre[d] = 0;
        nxt = m_cnt[d] + (up_i ? 1 : -1);
        if (nxt < 0 || nxt >= m) begin
          m_tc[d]  = 1'b1;
          m_ovf[d] = 1'b1;
          if (!Sat) m_cnt[d] = (nxt + m) % m;
        end else begin
          m_cnt[d] = nxt;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, " d0.count"}, 32'(cnt1 & 4'h0) | 32'(cnt0), 32'(m_cnt[0]));
    check({ph, " d0.tc"},    32'(tc0),  32'(m_tc[0]));
    check({ph, " d0.ovf"},   32'(ovf0), 32'(m_ovf[0]));
    check({ph, " d1.count"}, 32'(cnt1), 32'(m_cnt[1]));
    check({ph, " d1.tc"},    32'(tc1),  32'(m_tc[1]));
    check({ph, " d1.ovf"},   32'(ovf1), 32'(m_ovf[1]));
  endtask

  task automatic drive(input bit c, input bit l, input int lv, input bit e, input bit u);
    clr_i      = c;
    load_i     = l;
    load_val_i = 4'(lv);
    en_i       = e;
    up_i       = u;
  endtask

  task automatic tick(input string ph);
    @(posedge clk_i);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    compare_all(ph);
  endtask

  // Assert reset between edges, check immediately, hold it across an edge, then release.
  task automatic async_reset();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    @(posedge clk_i);
    #1;
    compare_all("rst_hold");
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    model_reset();
    #3;
    compare_all("reset");
    @(posedge clk_i);
    #1;
    compare_all("reset_edge");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Free-running up count: d0 wraps 15->0 repeatedly, d1 wraps 9->0 after 30 edges.
    repeat (52) tick("upcount");

    drive(1'b0, 1'b1, 7, 1'b1, 1'b1);
    tick("load7");
    drive(1'b0, 1'b1, 12, 1'b1, 1'b1);
    tick("load12_clamp");
    drive(1'b1, 1'b1, 5, 1'b1, 1'b1);
    tick("clr_vs_load");

    drive(1'b0, 1'b1, 1, 1'b1, 1'b0);
    tick("load1");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (9) tick("down");

    drive(1'b1, 1'b0, 0, 1'b0, 1'b1);
    tick("gap_clr");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    repeat (2) tick("gap_en");
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (5) tick("gap_off");
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    tick("gap_step");
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (2) tick("gap_hold");

    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    repeat (22) tick("pre_rst");
    async_reset();
    repeat (10) tick("resume");

    repeat (400) begin
      drive(($urandom_range(31) == 0), ($urandom_range(15) == 0), int'($urandom_range(15)),
            ($urandom_range(3) != 0), 1'($urandom_range(1)));
      tick("random");
    end
    async_reset();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
    repeat (8) tick("post_rst_down");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
